// File: rtl/hit_detect.sv
// Goose/bean collision detector: counts overlapping pixels per frame, decides
// hits at each frame boundary and keeps a saturating 4-digit BCD survival score.
module hit_detect #(
    parameter int HIT_THRESHOLD = 8,
    parameter int GRACE_FRAMES  = 30,
    parameter int SCORE_DIV     = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        goose,
    input  logic        bean,
    output logic        check_hit,
    output logic        hit_pulse,
    output logic [15:0] score_bcd,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        GRACE = 2'd0,
        RUN   = 2'd1,
        HIT   = 2'd2
    } state_t;

    localparam state_t     RESET_STATE = (GRACE_FRAMES == 0) ? RUN : GRACE;
    localparam logic [11:0] OV_MAX     = 12'hFFF;
    localparam logic [11:0] THRESHOLD  = 12'(HIT_THRESHOLD);
    localparam logic [7:0]  GRACE_LAST = (GRACE_FRAMES == 0) ? 8'd0 : 8'(GRACE_FRAMES - 1);
    localparam logic [7:0]  SCORE_LAST = 8'(SCORE_DIV - 1);

    state_t      state_q,     state_n;
    logic [11:0] ov_cnt,      ov_cnt_n;
    logic [7:0]  frame_cnt,   frame_cnt_n;
    logic [15:0] score_q,     score_n;
    logic        hit_pulse_q, hit_pulse_n;
    logic        check_hit_q;
    logic        ov;

    // Ripple BCD increment that sticks at 9999 instead of rolling over.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign ov = video_on & goose & bean;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            ov_cnt      <= 12'd0;
            frame_cnt   <= 8'd0;
            score_q     <= 16'h0000;
            hit_pulse_q <= 1'b0;
            check_hit_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            ov_cnt      <= ov_cnt_n;
            frame_cnt   <= frame_cnt_n;
            score_q     <= score_n;
            hit_pulse_q <= hit_pulse_n;
            check_hit_q <= (state_n == HIT);
        end
    end

    // A tick closes the frame on the count accumulated so far; a pixel
    // overlapping in that same cycle seeds the next frame instead.
    always_comb begin
        state_n     = state_q;
        ov_cnt_n    = ov_cnt;
        frame_cnt_n = frame_cnt;
        score_n     = score_q;
        hit_pulse_n = 1'b0;

        if (frame_tick) begin
            ov_cnt_n = (state_q == RUN) ? {11'd0, ov} : 12'd0;
            case (state_q)
                GRACE: begin
                    if (frame_cnt == GRACE_LAST) begin
                        state_n     = RUN;
                        frame_cnt_n = 8'd0;
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (ov_cnt >= THRESHOLD) begin
                        state_n     = HIT;
                        hit_pulse_n = 1'b1;
                    end else if (frame_cnt == SCORE_LAST) begin
                        frame_cnt_n = 8'd0;
                        score_n     = bcd_inc(score_q);
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state_n = HIT;
                end
            endcase
        end else if ((state_q == RUN) && ov && (ov_cnt != OV_MAX)) begin
            ov_cnt_n = ov_cnt + 12'd1;
        end
    end

    assign check_hit = check_hit_q;
    assign hit_pulse = hit_pulse_q;
    assign score_bcd = score_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hit_detect.sv
// Bench for hit_detect: scenario tasks compare the DUT against a frame-level
// behavioural model of grace, run, hit and scoring.
module tb_hit_detect;

    localparam int THR   = 8;
    localparam int GRACE = 3;
    localparam int DIV   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic        goose = 1'b0;
    logic        bean = 1'b0;
    logic        check_hit;
    logic        hit_pulse;
    logic [15:0] score_bcd;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Model: mode 0/1/2, frames completed in grace, frames since last score
    // point, overlaps in the open frame, decimal score, pulse flag.
    int m_mode = 0;
    int m_grace_done = 0;
    int m_run_frames = 0;
    int m_ovl = 0;
    int m_score = 0;
    bit m_pulse = 0;

    logic [20:0] observed;
    assign observed = {state, check_hit, hit_pulse, score_bcd};

    hit_detect #(
        .HIT_THRESHOLD(THR),
        .GRACE_FRAMES (GRACE),
        .SCORE_DIV    (DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .video_on  (video_on),
        .frame_tick(frame_tick),
        .goose     (goose),
        .bean      (bean),
        .check_hit (check_hit),
        .hit_pulse (hit_pulse),
        .score_bcd (score_bcd),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] model_outputs();
        return {2'(m_mode), (m_mode == 2), m_pulse, to_bcd(m_score)};
    endfunction

    task automatic model_step(input bit r, input bit t, input bit o);
        int closed;
        bit was_run;
        if (r) begin
            m_mode       = (GRACE == 0) ? 1 : 0;
            m_grace_done = 0;
            m_run_frames = 0;
            m_ovl        = 0;
            m_score      = 0;
            m_pulse      = 0;
        end else if (t) begin
            closed  = m_ovl;
            was_run = (m_mode == 1);
            m_pulse = 0;
            if (m_mode == 0) begin
                m_grace_done++;
                if (m_grace_done == GRACE) begin
                    m_mode       = 1;
                    m_run_frames = 0;
                end
            end else if (m_mode == 1) begin
                if (closed >= THR) begin
                    m_mode  = 2;
                    m_pulse = 1;
                end else begin
                    m_run_frames++;
                    if (m_run_frames == DIV) begin
                        m_run_frames = 0;
                        if (m_score < 9999) m_score++;
                    end
                end
            end
            m_ovl = (was_run && o) ? 1 : 0;
        end else begin
            m_pulse = 0;
            if (m_mode == 1 && o && m_ovl < 4095) m_ovl++;
        end
    endtask

    task automatic cycle(input logic vo, input logic g, input logic b,
                         input logic t, input logic r);
        video_on   = vo;
        goose      = g;
        bean       = b;
        frame_tick = t;
        reset      = r;
        @(posedge clk);
        model_step(r, t, vo & g & b);
        #1;
    endtask

    task automatic pixel(input logic vo, input logic g, input logic b);
        cycle(vo, g, b, 1'b0, 1'b0);
    endtask

    task automatic tick(input logic vo, input logic g, input logic b);
        cycle(vo, g, b, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Grace frames full of overlaps (including on the ticks) must not leak into RUN.
    task automatic enter_run();
        do_reset();
        for (int f = 0; f < GRACE; f++) begin
            for (int p = 0; p < 12; p++) pixel(1'b1, 1'b1, 1'b1);
            tick(1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (observed !== {2'd0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_state got %h want %h", observed, {2'd0, 1'b0, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_grace();
        do_reset();
        for (int f = 1; f <= GRACE + 1; f++) begin
            for (int p = 0; p < 10; p++) pixel(1'b1, 1'b1, 1'b1);
            tick(1'b1, 1'b1, 1'b1);
            checks++;
            if (observed !== model_outputs()) begin
                errors++;
                $display("[TB] FAIL grace_tick%0d got %h want %h", f, observed, model_outputs());
            end
        end
        checks++;
        if (check_hit !== 1'b1 || hit_pulse !== 1'b1 || state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL grace_first_run_hit got hit=%b pulse=%b state=%0d want 1 1 2",
                     check_hit, hit_pulse, state);
        end
    endtask

    task automatic test_threshold();
        enter_run();
        for (int n = 0; n < 7; n++) begin
            pixel(1'b1, 1'b1, 1'b1);
            pixel(1'b1, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1 || check_hit !== 1'b0 || hit_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL thr_7_no_hit got state=%0d hit=%b pulse=%b want 1 0 0",
                     state, check_hit, hit_pulse);
        end
        for (int n = 0; n < 8; n++) begin
            pixel(1'b1, 1'b1, 1'b1);
            pixel(1'b0, 1'b1, 1'b1);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (hit_pulse !== 1'b1 || check_hit !== 1'b1 || state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL thr_8_hit got pulse=%b hit=%b state=%0d want 1 1 2",
                     hit_pulse, check_hit, state);
        end
        pixel(1'b0, 1'b0, 1'b0);
        checks++;
        if (hit_pulse !== 1'b0 || check_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL thr_pulse_width got pulse=%b hit=%b want 0 1", hit_pulse, check_hit);
        end
    endtask

    task automatic test_gating();
        enter_run();
        for (int p = 0; p < 100; p++) pixel(1'b0, 1'b1, 1'b1);
        for (int p = 0; p < 100; p++) pixel(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1 || check_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gating_no_hit got state=%0d hit=%b want 1 0", state, check_hit);
        end
    endtask

    task automatic test_collision();
        enter_run();
        for (int p = 0; p < 7; p++) pixel(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (state !== 2'd1 || hit_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collision_excluded got state=%0d pulse=%b want 1 0", state, hit_pulse);
        end
        for (int p = 0; p < 7; p++) pixel(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd2 || hit_pulse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_seeded got state=%0d pulse=%b want 2 1", state, hit_pulse);
        end
    endtask

    task automatic test_random();
        logic g;
        do_reset();
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(30, 90);
            for (int p = 0; p < len; p++) begin
                g = 1'($urandom);
                pixel(1'($urandom), g, 1'($urandom));
            end
            tick(1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (observed !== model_outputs()) begin
                errors++;
                $display("[TB] FAIL random_frame%0d got %h want %h", f, observed, model_outputs());
            end
            if (m_mode == 2) do_reset();
        end
    endtask

    task automatic test_score();
        logic g;
        enter_run();
        for (int n = 0; n < 2 * 1234; n++) begin
            g = 1'($urandom);
            tick(1'($urandom), g, ~g);
        end
        checks++;
        if (score_bcd !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL score_1234 got %h want 1234", score_bcd);
        end
        for (int n = 0; n < 17700; n++) begin
            g = 1'($urandom);
            tick(1'($urandom), g, ~g);
            if (n % 1500 == 0) begin
                checks++;
                if (observed !== model_outputs()) begin
                    errors++;
                    $display("[TB] FAIL score_run%0d got %h want %h", n, observed, model_outputs());
                end
            end
        end
        checks++;
        if (score_bcd !== 16'h9999 || state !== 2'd1) begin
            errors++;
            $display("[TB] FAIL score_saturate got %h state=%0d want 9999 1", score_bcd, state);
        end
    endtask

    task automatic test_back_to_back();
        enter_run();
        for (int n = 0; n < 7; n++) tick(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 8; p++) pixel(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (score_bcd !== 16'h0003 || state !== 2'd2) begin
            errors++;
            $display("[TB] FAIL freeze_hit_tick got %h state=%0d want 0003 2", score_bcd, state);
        end
        for (int n = 0; n < 50; n++) tick(1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (score_bcd !== 16'h0003 || state !== 2'd2 || check_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL freeze_50_ticks got %h state=%0d hit=%b want 0003 2 1",
                     score_bcd, state, check_hit);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (observed !== {2'd0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_with_tick got %h want %h", observed, {2'd0, 1'b0, 1'b0, 16'h0000});
        end
    endtask

    initial begin
        test_reset();
        test_grace();
        test_threshold();
        test_gating();
        test_collision();
        test_random();
        test_score();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
